// File: rtl/ir_pkg.sv
// Shared types and constants for the IR command decoder.
package ir_pkg;

    typedef enum logic [2:0] {
        S_STOP = 3'd0,
        S_SEEK = 3'd1,
        S_REQ  = 3'd2,
        S_BUSY = 3'd3
    } ir_state_e;

    localparam int RED   = 0;
    localparam int GREEN = 1;
    localparam int BLUE  = 2;

    localparam logic [11:0] IR_DEFAULT_MASK = 12'hCE8;
    localparam int          STOP_CH         = 0;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/ir_debounce.sv
// Debounces a one-hot IR channel bus: emits a single commit pulse once the
// same valid channel has been sampled DEBOUNCE_CYCLES times in a row.
module ir_debounce #(
    parameter  int NUM_CH          = 4,
    parameter  int DEBOUNCE_CYCLES = 16,
    localparam int IDX_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] ir_ch,
    output logic              commit,
    output logic [IDX_W-1:0]  idx,
    output logic              sample_valid
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [NUM_CH-1:0] sample_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              stable;

    assign sample_valid = (ir_ch != '0) && ((ir_ch & (ir_ch - NUM_CH'(1))) == '0);
    assign stable       = (ir_ch == sample_q) && (cnt_q != '0);

    always_comb begin
        idx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ir_ch[i]) idx = IDX_W'(i);
        end
    end

    // Counter saturates at the threshold so a held input commits only once.
    always_comb begin
        cnt_d = '0;
        if (sample_valid) begin
            if (stable)
                cnt_d = (cnt_q == CNT_W'(DEBOUNCE_CYCLES)) ? cnt_q : cnt_q + CNT_W'(1);
            else
                cnt_d = CNT_W'(1);
        end
    end

    assign commit = sample_valid && (cnt_d == CNT_W'(DEBOUNCE_CYCLES))
                    && !(stable && (cnt_q == CNT_W'(DEBOUNCE_CYCLES)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_q <= '0;
            cnt_q    <= '0;
        end else begin
            sample_q <= ir_ch;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/ir_command_decoder.sv
// IR beacon command decoder: debounced instruction commit, colour match and
// pickup handshake. Optional IR-loss timeout enabled by IR_LOSS_TIMEOUT_EN.
module ir_command_decoder
    import ir_pkg::*;
#(
    parameter  int                                 NUM_CH          = 4,
    parameter  int                                 NUM_COLORS      = 3,
    parameter  logic [NUM_CH*NUM_COLORS-1:0]       CH_COLOR_MASK   = (NUM_CH*NUM_COLORS)'(IR_DEFAULT_MASK),
    parameter  int                                 DEBOUNCE_CYCLES = 16,
    parameter  int                                 TIMEOUT_CYCLES  = 65535,
    localparam int                                 IW              = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_CH-1:0]     ir_ch,
    input  logic [NUM_COLORS-1:0] color_detected,
    input  logic                  color_valid,
    input  logic                  pickup_ack,
    input  logic                  pickup_done,
    output logic [IW-1:0]         instr,
    output logic                  instr_valid,
    output logic [2:0]            state,
    output logic                  pickup_req,
    output logic                  stop,
    output logic                  abort,
    output logic [7:0]            pickup_count
);

    logic            commit;
    logic [IW-1:0]   commit_idx;
    logic            sample_valid;
    logic            stop_commit;
    logic            loss_hit;
    logic            match;

    ir_state_e       state_q;
    logic [IW-1:0]   instr_q;
    logic            instr_valid_q;
    logic            abort_q;
    logic [7:0]      count_q;

    logic [NUM_COLORS-1:0] mask_arr [NUM_CH];

    ir_debounce #(
        .NUM_CH          (NUM_CH),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk          (clk),
        .rst_n        (rst_n),
        .ir_ch        (ir_ch),
        .commit       (commit),
        .idx          (commit_idx),
        .sample_valid (sample_valid)
    );

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_mask
        assign mask_arr[gi] = CH_COLOR_MASK[gi*NUM_COLORS +: NUM_COLORS];
    end

    assign match       = color_valid & |(color_detected & mask_arr[instr_q]);
    assign stop_commit = commit && (commit_idx == IW'(STOP_CH));

`ifdef IR_LOSS_TIMEOUT_EN
    localparam int LW = $clog2(TIMEOUT_CYCLES + 1);
    logic [LW-1:0] loss_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            loss_q <= '0;
        else if (sample_valid)
            loss_q <= '0;
        else if (loss_q != LW'(TIMEOUT_CYCLES))
            loss_q <= loss_q + LW'(1);
    end

    assign loss_hit = !sample_valid && (loss_q == LW'(TIMEOUT_CYCLES - 1));
`else
    // Without the timeout the validity flag and limit are intentionally unused.
    logic unused_loss;
    assign unused_loss = sample_valid ^ (TIMEOUT_CYCLES == 0);
    assign loss_hit    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_STOP;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            abort_q       <= 1'b0;
            count_q       <= '0;
        end else begin
            abort_q <= 1'b0;
            if (commit) begin
                instr_q       <= commit_idx;
                instr_valid_q <= 1'b1;
            end
            if (loss_hit)
                instr_valid_q <= 1'b0;

            // Stop or IR loss overrides everything, including a coincident done.
            if (stop_commit || loss_hit) begin
                state_q <= S_STOP;
                abort_q <= (state_q == S_REQ) || (state_q == S_BUSY);
            end else begin
                case (state_q)
                    S_STOP: if (commit)      state_q <= S_SEEK;
                    S_SEEK: if (match)       state_q <= S_REQ;
                    S_REQ:  if (pickup_ack)  state_q <= S_BUSY;
                    S_BUSY: if (pickup_done) begin
                        state_q <= S_SEEK;
                        count_q <= sat_inc8(count_q);
                    end
                    default: state_q <= S_STOP;
                endcase
            end
        end
    end

    assign instr        = instr_q;
    assign instr_valid  = instr_valid_q;
    assign state        = state_q;
    assign pickup_req   = (state_q == S_REQ);
    assign stop         = (state_q == S_STOP);
    assign abort        = abort_q;
    assign pickup_count = count_q;

endmodule

// File: tb/tb_ir_command_decoder.sv
// Self-checking bench for ir_command_decoder; honours IR_LOSS_TIMEOUT_EN.
module tb_ir_command_decoder;
    import ir_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [3:0] ir_ch;
    logic [2:0] color_detected;
    logic       color_valid;
    logic       pickup_ack;
    logic       pickup_done;
    logic [1:0] instr;
    logic       instr_valid;
    logic [2:0] state;
    logic       pickup_req;
    logic       stop;
    logic       abort;
    logic [7:0] pickup_count;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_instr_q[$];
    int exp_cnt_q[$];

    ir_command_decoder #(
        .NUM_CH          (4),
        .NUM_COLORS      (3),
        .CH_COLOR_MASK   (12'hCE8),
        .DEBOUNCE_CYCLES (16),
        .TIMEOUT_CYCLES  (8)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ir_ch          (ir_ch),
        .color_detected (color_detected),
        .color_valid    (color_valid),
        .pickup_ack     (pickup_ack),
        .pickup_done    (pickup_done),
        .instr          (instr),
        .instr_valid    (instr_valid),
        .state          (state),
        .pickup_req     (pickup_req),
        .stop           (stop),
        .abort          (abort),
        .pickup_count   (pickup_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ir_ch = '0; color_detected = '0; color_valid = 1'b0;
        pickup_ack = 1'b0; pickup_done = 1'b0;
        tick(2);
        n_checks++; if (instr !== 2'd0)        begin n_fail++; $display("FAIL reset_instr: got %0d expected 0", instr); end
        n_checks++; if (instr_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_instr_valid: got %0b expected 0", instr_valid); end
        n_checks++; if (state !== S_STOP)      begin n_fail++; $display("FAIL reset_state: got %0d expected 0", state); end
        n_checks++; if (stop !== 1'b1)         begin n_fail++; $display("FAIL reset_stop: got %0b expected 1", stop); end
        n_checks++; if (pickup_req !== 1'b0)   begin n_fail++; $display("FAIL reset_req: got %0b expected 0", pickup_req); end
        n_checks++; if (abort !== 1'b0)        begin n_fail++; $display("FAIL reset_abort: got %0b expected 0", abort); end
        n_checks++; if (pickup_count !== 8'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", pickup_count); end
        rst_n = 1'b1;
        $display("txn reset released");
    endtask

    task automatic test_commit();
        int e;
        color_valid = 1'b1; color_detected = 3'(1 << BLUE);
        ir_ch = 4'b0010;
        exp_instr_q.push_back(1);
        tick(15);
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL commit_early_valid: got %0b expected 0", instr_valid); end
        n_checks++; if (state !== S_STOP)     begin n_fail++; $display("FAIL commit_early_state: got %0d expected 0", state); end
        tick(1);
        e = exp_instr_q.pop_front();
        n_checks++; if (instr !== 2'(e))      begin n_fail++; $display("FAIL commit_instr: got %0d expected %0d", instr, e); end
        n_checks++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL commit_valid: got %0b expected 1", instr_valid); end
        n_checks++; if (state !== S_SEEK)     begin n_fail++; $display("FAIL commit_state: got %0d expected 1", state); end
        n_checks++; if (pickup_req !== 1'b0)  begin n_fail++; $display("FAIL commit_req: got %0b expected 0", pickup_req); end
        tick(1);
        n_checks++; if (state !== S_REQ)      begin n_fail++; $display("FAIL match_state: got %0d expected 2", state); end
        n_checks++; if (pickup_req !== 1'b1)  begin n_fail++; $display("FAIL match_req: got %0b expected 1", pickup_req); end
        n_checks++; if (stop !== 1'b0)        begin n_fail++; $display("FAIL match_stop: got %0b expected 0", stop); end
        $display("txn commit instr=%0d state=%0d", instr, state);
    endtask

    task automatic test_handshake();
        int e;
        pickup_ack = 1'b1;
        tick(1);
        n_checks++; if (state !== S_BUSY)     begin n_fail++; $display("FAIL ack_state: got %0d expected 3", state); end
        n_checks++; if (pickup_req !== 1'b0)  begin n_fail++; $display("FAIL ack_req_fall: got %0b expected 0", pickup_req); end
        tick(1);
        n_checks++; if (state !== S_BUSY)     begin n_fail++; $display("FAIL ack_in_busy_state: got %0d expected 3", state); end
        pickup_ack = 1'b0;
        exp_cnt_q.push_back(1);
        pickup_done = 1'b1; tick(1); pickup_done = 1'b0;
        e = exp_cnt_q.pop_front();
        n_checks++; if (pickup_count !== 8'(e)) begin n_fail++; $display("FAIL done_count: got %0d expected %0d", pickup_count, e); end
        n_checks++; if (state !== S_SEEK)     begin n_fail++; $display("FAIL done_state: got %0d expected 1", state); end
        tick(1);
        pickup_done = 1'b1; tick(1); pickup_done = 1'b0;
        n_checks++; if (state !== S_REQ)      begin n_fail++; $display("FAIL done_in_req_state: got %0d expected 2", state); end
        n_checks++; if (pickup_count !== 8'd1) begin n_fail++; $display("FAIL done_in_req_count: got %0d expected 1", pickup_count); end
        $display("txn pickup count=%0d", pickup_count);
    endtask

    task automatic test_stop_with_done();
        pickup_ack = 1'b1; tick(1); pickup_ack = 1'b0;
        ir_ch = 4'b0001;
        tick(15);
        n_checks++; if (state !== S_BUSY)     begin n_fail++; $display("FAIL pre_stop_state: got %0d expected 3", state); end
        pickup_done = 1'b1; tick(1); pickup_done = 1'b0;
        n_checks++; if (state !== S_STOP)     begin n_fail++; $display("FAIL stop_state: got %0d expected 0", state); end
        n_checks++; if (abort !== 1'b1)       begin n_fail++; $display("FAIL stop_abort: got %0b expected 1", abort); end
        n_checks++; if (pickup_count !== 8'd1) begin n_fail++; $display("FAIL stop_count: got %0d expected 1", pickup_count); end
        n_checks++; if (instr !== 2'd0)       begin n_fail++; $display("FAIL stop_instr: got %0d expected 0", instr); end
        tick(1);
        n_checks++; if (abort !== 1'b0)       begin n_fail++; $display("FAIL abort_pulse: got %0b expected 0", abort); end
        n_checks++; if (stop !== 1'b1)        begin n_fail++; $display("FAIL stop_out: got %0b expected 1", stop); end
        $display("txn stop+done state=%0d count=%0d", state, pickup_count);
    endtask

    task automatic test_debounce_restart_and_mask();
        int e;
        ir_ch = 4'b0100; tick(10);
        ir_ch = 4'b1000; exp_instr_q.push_back(3); tick(15);
        n_checks++; if (instr !== 2'd0)       begin n_fail++; $display("FAIL restart_instr: got %0d expected 0", instr); end
        n_checks++; if (state !== S_STOP)     begin n_fail++; $display("FAIL restart_state: got %0d expected 0", state); end
        tick(1);
        e = exp_instr_q.pop_front();
        n_checks++; if (instr !== 2'(e))      begin n_fail++; $display("FAIL restart_commit: got %0d expected %0d", instr, e); end
        n_checks++; if (state !== S_SEEK)     begin n_fail++; $display("FAIL restart_seek: got %0d expected 1", state); end
        tick(1);
        n_checks++; if (state !== S_REQ)      begin n_fail++; $display("FAIL ch3_match: got %0d expected 2", state); end
        ir_ch = 4'b0100; exp_instr_q.push_back(2); tick(16);
        e = exp_instr_q.pop_front();
        n_checks++; if (instr !== 2'(e))      begin n_fail++; $display("FAIL change_in_req_instr: got %0d expected %0d", instr, e); end
        n_checks++; if (state !== S_REQ)      begin n_fail++; $display("FAIL change_in_req_state: got %0d expected 2", state); end
        n_checks++; if (abort !== 1'b0)       begin n_fail++; $display("FAIL change_in_req_abort: got %0b expected 0", abort); end
        pickup_ack = 1'b1; tick(1); pickup_ack = 1'b0;
        pickup_done = 1'b1; tick(1); pickup_done = 1'b0;
        tick(4);
        n_checks++; if (state !== S_SEEK)     begin n_fail++; $display("FAIL mask_miss_state: got %0d expected 1", state); end
        n_checks++; if (pickup_req !== 1'b0)  begin n_fail++; $display("FAIL mask_miss_req: got %0b expected 0", pickup_req); end
        n_checks++; if (pickup_count !== 8'd2) begin n_fail++; $display("FAIL mask_count: got %0d expected 2", pickup_count); end
        color_detected = 3'(1 << RED); color_valid = 1'b0; tick(2);
        n_checks++; if (state !== S_SEEK)     begin n_fail++; $display("FAIL color_invalid_state: got %0d expected 1", state); end
        color_valid = 1'b1; tick(1);
        n_checks++; if (state !== S_REQ)      begin n_fail++; $display("FAIL red_match_state: got %0d expected 2", state); end
        $display("txn mask instr=%0d state=%0d", instr, state);
    endtask

    task automatic test_saturation();
        int e;
        for (int i = 1; i <= 300; i++) begin
            exp_cnt_q.push_back((2 + i > 255) ? 255 : 2 + i);
            pickup_ack = 1'b1; tick(1); pickup_ack = 1'b0;
            pickup_done = 1'b1; tick(1); pickup_done = 1'b0;
            e = exp_cnt_q.pop_front();
            n_checks++; if (pickup_count !== 8'(e)) begin n_fail++; $display("FAIL sat_count[%0d]: got %0d expected %0d", i, pickup_count, e); end
            $display("txn pickup %0d count=%0d", i, pickup_count);
            tick(1);
        end
        n_checks++; if (state !== S_REQ)      begin n_fail++; $display("FAIL sat_end_state: got %0d expected 2", state); end
    endtask

    task automatic test_async_reset();
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (pickup_req !== 1'b0)   begin n_fail++; $display("FAIL async_rst_req: got %0b expected 0", pickup_req); end
        n_checks++; if (state !== S_STOP)      begin n_fail++; $display("FAIL async_rst_state: got %0d expected 0", state); end
        n_checks++; if (pickup_count !== 8'd0) begin n_fail++; $display("FAIL async_rst_count: got %0d expected 0", pickup_count); end
        tick(1);
        rst_n = 1'b1;
        $display("txn async reset");
    endtask

    task automatic test_multihot();
        logic [2:0] exp_state;
        logic       exp_iv;
        color_valid = 1'b0;
        ir_ch = 4'b0100; tick(16);
        n_checks++; if (instr !== 2'd2)       begin n_fail++; $display("FAIL mh_setup_instr: got %0d expected 2", instr); end
        ir_ch = 4'b0110; tick(40);
`ifdef IR_LOSS_TIMEOUT_EN
        exp_state = S_STOP; exp_iv = 1'b0;
`else
        exp_state = S_SEEK; exp_iv = 1'b1;
`endif
        n_checks++; if (instr !== 2'd2)       begin n_fail++; $display("FAIL multihot_instr: got %0d expected 2", instr); end
        n_checks++; if (instr_valid !== exp_iv) begin n_fail++; $display("FAIL multihot_valid: got %0b expected %0b", instr_valid, exp_iv); end
        n_checks++; if (state !== exp_state)  begin n_fail++; $display("FAIL multihot_state: got %0d expected %0d", state, exp_state); end
        $display("txn multihot instr=%0d state=%0d", instr, state);
    endtask

`ifdef IR_LOSS_TIMEOUT_EN
    task automatic test_timeout();
        rst_n = 1'b0; ir_ch = '0; color_valid = 1'b0; tick(1); rst_n = 1'b1;
        ir_ch = 4'b0010; tick(16);
        n_checks++; if (state !== S_SEEK)     begin n_fail++; $display("FAIL to_setup_state: got %0d expected 1", state); end
        ir_ch = 4'b0000; tick(7);
        n_checks++; if (state !== S_SEEK)     begin n_fail++; $display("FAIL to_early_state: got %0d expected 1", state); end
        n_checks++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL to_early_valid: got %0b expected 1", instr_valid); end
        tick(1);
        n_checks++; if (state !== S_STOP)     begin n_fail++; $display("FAIL to_state: got %0d expected 0", state); end
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL to_valid: got %0b expected 0", instr_valid); end
        ir_ch = 4'b0010; tick(16);
        n_checks++; if (state !== S_SEEK)     begin n_fail++; $display("FAIL to_recommit_state: got %0d expected 1", state); end
        $display("txn timeout state=%0d", state);
    endtask
`endif

    initial begin
        test_reset();
        test_commit();
        test_handshake();
        test_stop_with_done();
        test_debounce_restart_and_mask();
        test_saturation();
        test_async_reset();
        test_multihot();
`ifdef IR_LOSS_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
